// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA key sequencer (optional RSA_SEQ_TIMEOUT_EN watchdog lives in the top)
package rsa_pkg;

    localparam int KEY_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_ENC = 1'b0;
    localparam logic PORT_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KG_START = 3'd1,
        ST_KG_WAIT  = 3'd2,
        ST_READY    = 3'd3,
        ST_ME_START = 3'd4,
        ST_ME_WAIT  = 3'd5,
        ST_FAULT    = 3'd6
    } rsa_state_e;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rsa_rr_arb2.sv
// rtl/rsa_rr_arb2.sv - two-way round-robin arbiter; pointer advances only when a granted job completes
module rsa_rr_arb2
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_port,
    output logic [1:0] grant,
    output logic       grant_port
);

    logic last;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= PORT_DEC;
        end else if (done) begin
            last <= done_port;
        end
    end

    // A lone request wins outright; contention goes to the port not served last.
    always_comb begin
        grant_port = (req == 2'b11) ? ~last : req[1];
        grant      = (req == 2'b00) ? 2'b00 : port_onehot(grant_port);
    end

endmodule

// File: rtl/rsa_key_sequencer.sv
// rtl/rsa_key_sequencer.sv - keygen sequencing and shared modexp scheduling for encrypt/decrypt ports
// Optional watchdog on KG_WAIT/ME_WAIT enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_key_sequencer
    import rsa_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [KEY_W-1:0]    cfg_p,
    input  logic [KEY_W-1:0]    cfg_q,
    input  logic [KEY_W-1:0]    cfg_e,
    output logic                kg_start,
    output logic [KEY_W-1:0]    kg_p,
    output logic [KEY_W-1:0]    kg_q,
    output logic [KEY_W-1:0]    kg_e,
    input  logic [DATA_W-1:0]   kg_n,
    input  logic [DATA_W-1:0]   kg_d,
    input  logic                kg_finished,
    output logic                me_start,
    output logic [DATA_W-1:0]   me_base,
    output logic [DATA_W-1:0]   me_exp,
    output logic [DATA_W-1:0]   me_mod,
    input  logic                me_done,
    input  logic [DATA_W-1:0]   me_result,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                key_valid,
    output logic                fault
);

    localparam logic [2:0] S_IDLE     = 3'(ST_IDLE);
    localparam logic [2:0] S_KG_START = 3'(ST_KG_START);
    localparam logic [2:0] S_KG_WAIT  = 3'(ST_KG_WAIT);
    localparam logic [2:0] S_READY    = 3'(ST_READY);
    localparam logic [2:0] S_ME_START = 3'(ST_ME_START);
    localparam logic [2:0] S_ME_WAIT  = 3'(ST_ME_WAIT);
    localparam logic [2:0] S_FAULT    = 3'(ST_FAULT);

    logic [2:0]        state;
    logic [DATA_W-1:0] phi;
    logic [DATA_W-1:0] n_key;
    logic [DATA_W-1:0] d_key;
    logic              cur_port;

    logic              cfg_fire;
    logic [DATA_W-1:0] p_minus1;
    logic [DATA_W-1:0] q_minus1;
    logic [DATA_W-1:0] cfg_phi;
    logic              cfg_bad;
    logic [DATA_W-1:0] d_norm;

    logic [1:0]        arb_req;
    logic [1:0]        arb_grant;
    logic              arb_port;
    logic              grant_fire;
    logic              job_done;
    logic [DATA_W-1:0] grant_word;
    logic              wd_expired;

    assign cfg_ready = (state == S_IDLE) || (state == S_READY) || (state == S_FAULT);
    assign kg_start  = (state == S_KG_START);
    assign me_start  = (state == S_ME_START);
    assign cfg_fire  = cfg_valid && cfg_ready;

    assign p_minus1 = DATA_W'(cfg_p) - DATA_W'(1);
    assign q_minus1 = DATA_W'(cfg_q) - DATA_W'(1);
    assign cfg_phi  = p_minus1 * q_minus1;
    assign cfg_bad  = (cfg_p < KEY_W'(2)) || (cfg_q < KEY_W'(2)) || (cfg_e < KEY_W'(2)) ||
                      (DATA_W'(cfg_e) >= cfg_phi);

    // Keygen returns the raw Euclid coefficient; one add of phi brings it into [0, phi).
    assign d_norm = kg_d[DATA_W-1] ? (kg_d + phi) : kg_d;

    // A config accepted in READY pre-empts any pending job request.
    assign arb_req    = ((state == S_READY) && !cfg_fire) ? req_valid : 2'b00;
    assign grant_fire = |arb_grant;
    assign req_ready  = arb_grant;
    assign job_done   = (state == S_ME_WAIT) && me_done;
    assign grant_word = arb_port ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

    rsa_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (arb_req),
        .done       (job_done),
        .done_port  (cur_port),
        .grant      (arb_grant),
        .grant_port (arb_port)
    );

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || ((state != S_KG_WAIT) && (state != S_ME_WAIT))) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog the wait states never give up.
    assign wd_expired = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            kg_p      <= '0;
            kg_q      <= '0;
            kg_e      <= '0;
            phi       <= '0;
            n_key     <= '0;
            d_key     <= '0;
            me_base   <= '0;
            me_exp    <= '0;
            me_mod    <= '0;
            cur_port  <= PORT_ENC;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            key_valid <= 1'b0;
            fault     <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                S_IDLE, S_READY, S_FAULT: begin
                    if (cfg_fire) begin
                        kg_p      <= cfg_p;
                        kg_q      <= cfg_q;
                        kg_e      <= cfg_e;
                        phi       <= cfg_phi;
                        key_valid <= 1'b0;
                        fault     <= cfg_bad;
                        state     <= cfg_bad ? S_FAULT : S_KG_START;
                    end else if (grant_fire) begin
                        me_base  <= grant_word;
                        me_exp   <= (arb_port == PORT_ENC) ? DATA_W'(kg_e) : d_key;
                        me_mod   <= n_key;
                        cur_port <= arb_port;
                        state    <= S_ME_START;
                    end
                end
                S_KG_START: begin
                    state <= S_KG_WAIT;
                end
                S_KG_WAIT: begin
                    if (kg_finished) begin
                        n_key     <= kg_n;
                        d_key     <= d_norm;
                        key_valid <= 1'b1;
                        state     <= S_READY;
                    end else if (wd_expired) begin
                        fault     <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= S_FAULT;
                    end
                end
                S_ME_START: begin
                    state <= S_ME_WAIT;
                end
                S_ME_WAIT: begin
                    if (me_done) begin
                        rsp_valid <= port_onehot(cur_port);
                        rsp_data  <= me_result;
                        state     <= S_READY;
                    end else if (wd_expired) begin
                        fault     <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= S_FAULT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_key_sequencer.sv
// tb/tb_rsa_key_sequencer.sv - randomized self-checking bench with keygen/modexp models and a job scoreboard
module tb_rsa_key_sequencer;

    localparam int KW = 8;
    localparam int DW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid, cfg_ready;
    logic [KW-1:0] cfg_p, cfg_q, cfg_e;
    logic          kg_start;
    logic [KW-1:0] kg_p, kg_q, kg_e;
    logic [DW-1:0] kg_n, kg_d;
    logic          kg_finished;
    logic          me_start;
    logic [DW-1:0] me_base, me_exp, me_mod;
    logic          me_done;
    logic [DW-1:0] me_result;
    logic [1:0]    req_valid, req_ready, rsp_valid;
    logic [2*DW-1:0] req_data;
    logic [DW-1:0] rsp_data;
    logic          key_valid, fault;

    always #5 clk = ~clk;

    rsa_key_sequencer #(.KEY_W(KW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_e(cfg_e),
        .kg_start(kg_start), .kg_p(kg_p), .kg_q(kg_q), .kg_e(kg_e),
        .kg_n(kg_n), .kg_d(kg_d), .kg_finished(kg_finished),
        .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
        .me_done(me_done), .me_result(me_result),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .key_valid(key_valid), .fault(fault)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int port;
        int base;
        int res;
    } job_t;

    job_t jobq[$];
    int   grant_log[$];
    bit   key_m = 0;
    int   n_m, e_m, d_m;
    int   n_p, e_p, d_p;
    int   last_m = 1;
    int   kg_count = 0;
    int   last_rsp = -1;
    int   me_dmin = 0, me_dmax = 5;

    function automatic int modpow(input int b, input int e, input int m);
        longint r = 1;
        longint bb = longint'(b) % m;
        int ee = e;
        while (ee > 0) begin
            if (ee[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return int'(r);
    endfunction

    function automatic int inv_mod(input int e, input int phi);
        for (int d = 1; d < phi; d++)
            if ((d * e) % phi == 1) return d;
        return 0;
    endfunction

    function automatic void egcd(input int a, input int m, output int x, output int g);
        int ro = a, r = m, so = 1, s = 0, q, t;
        while (r != 0) begin
            q = ro / r;
            t = r;  r = ro - q * r;  ro = t;
            t = s;  s = so - q * s;  so = t;
        end
        x = so;
        g = ro;
    endfunction

    // Keygen datapath model: finishes with the raw (possibly negative) Euclid coefficient, or never if gcd != 1.
    initial begin : kg_model
        int cnt, kp, kq, ke, x, g;
        kg_finished = 1'b0; kg_n = '0; kg_d = '0;
        cnt = -1; kp = 0; kq = 0; x = 0;
        forever begin
            @(posedge clk); #3;
            if (reset) begin
                kg_finished = 1'b0;
                cnt = -1;
            end else if (kg_start) begin
                kg_finished = 1'b0;
                kp = int'(kg_p); kq = int'(kg_q); ke = int'(kg_e);
                egcd(ke, (kp - 1) * (kq - 1), x, g);
                cnt = (g == 1) ? int'($urandom_range(0, 6)) : -1;
            end else if (cnt == 0) begin
                kg_finished = 1'b1;
                kg_n = 16'(kp * kq);
                kg_d = 16'(x);
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
        end
    end

    // Modexp core model: ignores reset, so a job dropped by reset still pulses me_done later.
    initial begin : me_model
        int cnt, mb, mx, mm;
        bit busy;
        me_done = 1'b0; me_result = '0;
        busy = 0; cnt = 0; mb = 0; mx = 0; mm = 1;
        forever begin
            @(posedge clk); #3;
            me_done = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    me_done = 1'b1;
                    me_result = 16'(modpow(mb, mx, mm));
                    busy = 0;
                end else begin
                    cnt--;
                end
            end
            if (me_start) begin
                mb = int'(me_base); mx = int'(me_exp); mm = int'(me_mod);
                busy = 1;
                cnt = int'($urandom_range(me_dmin, me_dmax));
            end
        end
    end

    task automatic check_grant();
        logic [1:0] expg = 2'b00;
        int pick = 0;
        job_t j;
        if (key_m && jobq.size() == 0 && !cfg_valid && req_valid != 2'b00) begin
            pick = (req_valid == 2'b11) ? 1 - last_m : ((req_valid == 2'b10) ? 1 : 0);
            expg = (pick == 1) ? 2'b10 : 2'b01;
        end
        check("req_ready", 32'(req_ready), 32'(expg));
        if (expg != 2'b00 && req_ready == expg) begin
            j.port = pick;
            j.base = int'(pick == 1 ? req_data[2*DW-1:DW] : req_data[DW-1:0]);
            j.res  = modpow(j.base, pick == 1 ? d_m : e_m, n_m);
            jobq.push_back(j);
            grant_log.push_back(pick);
        end
    endtask

    task automatic check_regs();
        job_t j;
        if (kg_start) kg_count++;
        if (rsp_valid != 2'b00) begin
            if (jobq.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 0);
            end else begin
                j = jobq.pop_front();
                check("rsp_valid", 32'(rsp_valid), (j.port == 1) ? 2 : 1);
                check("rsp_data", 32'(rsp_data), 32'(j.res));
                last_m = j.port;
                last_rsp = int'(rsp_data);
            end
        end
        if (me_start) begin
            if (jobq.size() == 0) begin
                check("me_start_spurious", 32'(me_start), 0);
            end else begin
                j = jobq[0];
                check("me_base", 32'(me_base), 32'(j.base));
                check("me_exp", 32'(me_exp), 32'((j.port == 1) ? d_m : e_m));
                check("me_mod", 32'(me_mod), 32'(n_m));
            end
        end
    endtask

    task automatic step();
        #1;
        check_grant();
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic check_reset_vals();
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_kg_start", 32'(kg_start), 0);
        check("rst_me_start", 32'(me_start), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_me_mod", 32'(me_mod), 0);
        check("rst_kg_p", 32'(kg_p), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_valid = 1'b0; req_valid = 2'b00;
        step();
        reset = 1'b0;
        jobq.delete();
        key_m = 0;
        last_m = 1;
        check_reset_vals();
    endtask

    task automatic do_cfg(input int p, input int q, input int e, output bit ok);
        int phi;
        bit bad;
        phi = (p - 1) * (q - 1);
        bad = (p < 2) || (q < 2) || (e < 2) || (e >= phi);
        check("cfg_ready_pre", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_p = 8'(p); cfg_q = 8'(q); cfg_e = 8'(e);
        step();
        key_m = 0;
        cfg_valid = 1'b0;
        check("kg_start_latency", 32'(kg_start), 32'(!bad));
        check("fault_after_cfg", 32'(fault), 32'(bad));
        check("key_valid_cleared", 32'(key_valid), 0);
        if (!bad) begin
            check("kg_p", 32'(kg_p), 32'(p));
            check("kg_q", 32'(kg_q), 32'(q));
            check("kg_e", 32'(kg_e), 32'(e));
            n_p = p * q;
            e_p = e;
            d_p = inv_mod(e, phi);
        end
        ok = !bad;
    endtask

    task automatic wait_key();
        for (int i = 0; i < 40 && !key_valid; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data = $urandom;
            step();
        end
        check("key_valid_set", 32'(key_valid), 1);
        n_m = n_p; e_m = e_p; d_m = d_p;
        key_m = key_valid;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        for (int i = 0; i < 200 && jobq.size() != 0; i++) step();
        check("drain", 32'(jobq.size()), 0);
    endtask

    task automatic traffic(input int cycles, input bit both);
        for (int i = 0; i < cycles; i++) begin
            req_valid = both ? 2'b11 : 2'($urandom_range(0, 3));
            req_data = $urandom;
            step();
        end
        drain();
    endtask

    initial begin : main
        bit ok;
        int n;
        reset = 1'b1; cfg_valid = 1'b0; cfg_p = '0; cfg_q = '0; cfg_e = '0;
        req_valid = 2'b11; req_data = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals();

        // Textbook key; requests held while idle must never be granted.
        kg_count = 0;
        do_cfg(61, 53, 17, ok);
        wait_key();
        check("kg_start_once", 32'(kg_count), 1);
        check("n_via_d", 32'(d_m), 2753);

        req_valid = 2'b01; req_data = {16'd0, 16'd65};
        step();
        drain();
        check("enc_65", 32'(last_rsp), 2790);
        req_valid = 2'b10; req_data = {16'd2790, 16'd0};
        step();
        drain();
        check("dec_2790", 32'(last_rsp), 65);

        traffic(300, 1'b0);
        grant_log.delete();
        traffic(60, 1'b1);
        check("alt_count", 32'(grant_log.size() >= 4), 1);
        for (int i = 1; i < grant_log.size(); i++)
            check("alternate", 32'(grant_log[i]), 32'(1 - grant_log[i-1]));

        // Config held off while a job is in flight.
        me_dmin = 6; me_dmax = 6;
        req_valid = 2'b01; req_data = {16'd0, 16'd100};
        step();
        req_valid = 2'b00;
        step();
        cfg_valid = 1'b1; cfg_p = 8'd1; cfg_q = 8'd1; cfg_e = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("cfg_held_busy", 32'(cfg_ready), 0);
        end
        cfg_valid = 1'b0;
        drain();
        check("busy_no_fault", 32'(fault), 0);
        check("busy_key_kept", 32'(key_valid), 1);
        me_dmin = 0; me_dmax = 5;

        // Config in READY beats simultaneous requests; e = phi-1 boundary.
        req_valid = 2'b11;
        do_cfg(3, 3, 3, ok);
        wait_key();
        traffic(40, 1'b0);

        // Range-check faults.
        kg_count = 0;
        do_cfg(1, 53, 17, ok);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) step();
        check("fault_sticky", 32'(fault), 1);
        check("fault_no_key", 32'(key_valid), 0);
        check("fault_ready", 32'(cfg_ready), 1);
        do_cfg(3, 3, 4, ok);
        do_cfg(5, 3, 1, ok);
        check("fault_no_kg_start", 32'(kg_count), 0);
        do_cfg(5, 3, 7, ok);
        wait_key();
        check("d_5_3_7", 32'(d_m), 7);
        traffic(40, 1'b0);

        // gcd(e, phi) != 1: keygen never finishes.
        do_cfg(7, 5, 6, ok);
        req_valid = 2'b00;
`ifdef RSA_SEQ_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 3 * TO && !fault; i++) begin
            step();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TO + 1));
        check("timeout_fault", 32'(fault), 1);
        check("timeout_key", 32'(key_valid), 0);
`else
        for (int i = 0; i < 150; i++) step();
        check("hang_no_fault", 32'(fault), 0);
        check("hang_no_key", 32'(key_valid), 0);
        check("hang_busy", 32'(cfg_ready), 0);
`endif
        do_reset();

        // Reset while a job is in ME_WAIT: job is dropped silently.
        do_cfg(61, 53, 17, ok);
        wait_key();
        me_dmin = 10; me_dmax = 10;
        req_valid = 2'b10; req_data = {16'd1234, 16'd0};
        step();
        req_valid = 2'b00;
        step();
        step();
        step();
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 25; i++) begin
            step();
            check("no_rsp_after_reset", 32'(rsp_valid), 0);
        end
        me_dmin = 0; me_dmax = 5;

        // Pointer back at its reset value: port 0 wins first contention.
        do_cfg(61, 53, 17, ok);
        wait_key();
        grant_log.delete();
        req_valid = 2'b11; req_data = $urandom;
        step();
        check("first_grant_port0", 32'((grant_log.size() > 0) ? grant_log[0] : 9), 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

endmodule
